// File: rtl/heater_enable_sequencer_if.sv
// rtl/heater_enable_sequencer_if.sv - control/status bundle between enable-mask source and heater sequencer
interface heater_enable_sequencer_if #(
  parameter int N = 12
);
  logic [N-1:0] req_enable;
  logic [N-1:0] err_in;
  logic [N-1:0] err_clear_req;
  logic [N-1:0] enable_out;
  logic [N-1:0] err_clear_out;
  logic [N-1:0] err_sticky;
  logic         busy;
  logic         at_limit;

  modport master (
    output req_enable, err_in, err_clear_req,
    input  enable_out, err_clear_out, err_sticky, busy, at_limit
  );

  modport slave (
    input  req_enable, err_in, err_clear_req,
    output enable_out, err_clear_out, err_sticky, busy, at_limit
  );
endinterface

// File: rtl/heater_enable_sequencer.sv
// rtl/heater_enable_sequencer.sv - staggered, current-capped heater enable sequencer with sticky error latching
module heater_enable_sequencer #(
  parameter int N      = 12,
  parameter int DWELL  = 1024,
  parameter int MAX_ON = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  heater_enable_sequencer_if.slave    io_bus
);

  localparam int CW = $clog2(N + 1);
  localparam int DW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] MAX_ON_C   = CW'(MAX_ON);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL - 1);

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_DWELL = 1'b1;

  logic [N-1:0]  r_enable;
  logic [N-1:0]  r_err_sticky;
  logic [N-1:0]  r_err_clear;
  logic          r_busy;
  logic          r_at_limit;
  logic [0:0]    r_state;
  logic [DW-1:0] r_dwell_cnt;

  logic [N-1:0]  w_target;
  logic [N-1:0]  w_kept;
  logic [N-1:0]  w_pending;
  logic [N-1:0]  w_pick;
  logic [N-1:0]  w_sticky_nxt;
  logic [N-1:0]  w_enable_nxt;
  logic [0:0]    w_state_nxt;
  logic [DW-1:0] w_dwell_nxt;

  function automatic logic [CW-1:0] f_popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // A new error always wins over a clear request arriving in the same cycle.
  assign w_sticky_nxt = io_bus.err_in |
                        (r_err_sticky & ~(io_bus.err_clear_req & ~io_bus.err_in));

  assign w_target  = io_bus.req_enable & ~r_err_sticky;
  assign w_kept    = r_enable & w_target;
  assign w_pending = w_target & ~r_enable;
  assign w_pick    = w_pending & (-w_pending);

  // Turn-offs apply unconditionally; the cap is checked against what survives them.
  always_comb begin
    w_enable_nxt = w_kept;
    w_state_nxt  = r_state;
    w_dwell_nxt  = r_dwell_cnt;
    case (r_state)
      ST_READY: begin
        if ((w_pending != '0) && (f_popcount(w_kept) < MAX_ON_C)) begin
          w_enable_nxt = w_kept | w_pick;
          w_state_nxt  = ST_DWELL;
          w_dwell_nxt  = DWELL_LOAD;
        end
      end
      default: begin
        if (r_dwell_cnt == '0) begin
          w_state_nxt = ST_READY;
        end else begin
          w_dwell_nxt = r_dwell_cnt - DW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable     <= '0;
      r_err_sticky <= '0;
      r_err_clear  <= '0;
      r_busy       <= 1'b0;
      r_at_limit   <= 1'b0;
      r_state      <= ST_READY;
      r_dwell_cnt  <= '0;
    end else begin
      r_enable     <= w_enable_nxt;
      r_err_sticky <= w_sticky_nxt;
      r_err_clear  <= io_bus.err_clear_req;
      r_busy       <= ((w_target & ~w_enable_nxt) != '0);
      r_at_limit   <= (f_popcount(w_enable_nxt) == MAX_ON_C);
      r_state      <= w_state_nxt;
      r_dwell_cnt  <= w_dwell_nxt;
    end
  end

  assign io_bus.enable_out    = r_enable;
  assign io_bus.err_clear_out = r_err_clear;
  assign io_bus.err_sticky    = r_err_sticky;
  assign io_bus.busy          = r_busy;
  assign io_bus.at_limit      = r_at_limit;

endmodule

// File: tb/tb_heater_enable_sequencer.sv
// tb/tb_heater_enable_sequencer.sv - directed self-checking bench for heater_enable_sequencer
module tb_heater_enable_sequencer;
  localparam int N = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  heater_enable_sequencer_if #(.N(N)) bus_a ();
  heater_enable_sequencer_if #(.N(N)) bus_b ();

  heater_enable_sequencer #(.N(N), .DWELL(4), .MAX_ON(12)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus_a.slave)
  );

  heater_enable_sequencer #(.N(N), .DWELL(1), .MAX_ON(3)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus_b.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.req_enable = '0; bus_a.err_in = '0; bus_a.err_clear_req = '0;
    bus_b.req_enable = '0; bus_b.err_in = '0; bus_b.err_clear_req = '0;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({bus_a.enable_out, bus_a.err_clear_out, bus_a.err_sticky, bus_a.busy, bus_a.at_limit} !== 38'd0)
      $display("FAIL reset_a: got en=%h clr=%h st=%h busy=%b lim=%b, want all 0",
               bus_a.enable_out, bus_a.err_clear_out, bus_a.err_sticky, bus_a.busy, bus_a.at_limit);
    else passed++;
    checks++;
    if ({bus_b.enable_out, bus_b.err_clear_out, bus_b.err_sticky, bus_b.busy, bus_b.at_limit} !== 38'd0)
      $display("FAIL reset_b: got en=%h busy=%b lim=%b, want all 0",
               bus_b.enable_out, bus_b.busy, bus_b.at_limit);
    else passed++;
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if (bus_a.enable_out !== 12'h000 || bus_a.busy !== 1'b0)
      $display("FAIL idle_after_reset: got en=%h busy=%b, want 000/0", bus_a.enable_out, bus_a.busy);
    else passed++;
  endtask

  task automatic test_stagger();
    logic [N-1:0] exp_en;
    bus_a.req_enable = 12'hFFF;
    for (int c = 1; c <= 60; c++) begin
      step();
      exp_en = '0;
      for (int k = 0; k < N; k++) if (1 + 5 * k <= c) exp_en[k] = 1'b1;
      checks++;
      if (bus_a.enable_out !== exp_en)
        $display("FAIL stagger_en c=%0d: got %h, want %h", c, bus_a.enable_out, exp_en);
      else passed++;
      checks++;
      if (bus_a.busy !== (c < 56))
        $display("FAIL stagger_busy c=%0d: got %b, want %b", c, bus_a.busy, (c < 56));
      else passed++;
    end
    checks++;
    if (bus_a.at_limit !== 1'b1)
      $display("FAIL stagger_at_limit: got %b, want 1", bus_a.at_limit);
    else passed++;
  endtask

  task automatic test_error();
    bus_a.err_in = 12'h020;
    step();
    bus_a.err_in = 12'h000;
    checks++;
    if (bus_a.err_sticky !== 12'h020)
      $display("FAIL err_sticky_set: got %h, want 020", bus_a.err_sticky);
    else passed++;
    step();
    checks++;
    if (bus_a.enable_out !== 12'hFDF)
      $display("FAIL err_disable: got %h, want FDF", bus_a.enable_out);
    else passed++;
    repeat (5) step();
    checks++;
    if (bus_a.enable_out !== 12'hFDF || bus_a.err_sticky !== 12'h020)
      $display("FAIL err_hold: got en=%h st=%h, want FDF/020", bus_a.enable_out, bus_a.err_sticky);
    else passed++;
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.at_limit !== 1'b0)
      $display("FAIL err_flags: got busy=%b lim=%b, want 0/0", bus_a.busy, bus_a.at_limit);
    else passed++;
  endtask

  task automatic test_clear();
    bus_a.err_in = 12'h020;
    bus_a.err_clear_req = 12'h020;
    step();
    checks++;
    if (bus_a.err_sticky !== 12'h020 || bus_a.err_clear_out !== 12'h020)
      $display("FAIL clear_set_wins: got st=%h clr=%h, want 020/020", bus_a.err_sticky, bus_a.err_clear_out);
    else passed++;
    bus_a.err_in = 12'h000;
    step();
    checks++;
    if (bus_a.err_sticky !== 12'h000 || bus_a.err_clear_out !== 12'h020 || bus_a.enable_out !== 12'hFDF)
      $display("FAIL clear_sticky: got st=%h clr=%h en=%h, want 000/020/FDF",
               bus_a.err_sticky, bus_a.err_clear_out, bus_a.enable_out);
    else passed++;
    bus_a.err_clear_req = 12'h000;
    step();
    checks++;
    if (bus_a.enable_out !== 12'hFFF || bus_a.err_clear_out !== 12'h000)
      $display("FAIL clear_reenable: got en=%h clr=%h, want FFF/000", bus_a.enable_out, bus_a.err_clear_out);
    else passed++;
    checks++;
    if (bus_a.at_limit !== 1'b1 || bus_a.busy !== 1'b0)
      $display("FAIL clear_flags: got lim=%b busy=%b, want 1/0", bus_a.at_limit, bus_a.busy);
    else passed++;
  endtask

  task automatic test_limit();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{12'h001, 12'h001, 12'h003, 12'h003, 12'h007};
    bus_b.req_enable = 12'hFFF;
    for (int e = 0; e < 5; e++) begin
      step();
      checks++;
      if (bus_b.enable_out !== exp_seq[e])
        $display("FAIL limit_ramp e=%0d: got %h, want %h", e + 1, bus_b.enable_out, exp_seq[e]);
      else passed++;
    end
    checks++;
    if (bus_b.at_limit !== 1'b1)
      $display("FAIL limit_reached: got %b, want 1", bus_b.at_limit);
    else passed++;
    bus_b.req_enable = 12'hFFD;
    step();
    checks++;
    if (bus_b.enable_out !== 12'h005 || bus_b.at_limit !== 1'b0)
      $display("FAIL limit_drop: got en=%h lim=%b, want 005/0", bus_b.enable_out, bus_b.at_limit);
    else passed++;
    step();
    checks++;
    if (bus_b.enable_out !== 12'h00D || bus_b.at_limit !== 1'b1)
      $display("FAIL limit_refill: got en=%h lim=%b, want 00D/1", bus_b.enable_out, bus_b.at_limit);
    else passed++;
    repeat (3) step();
    checks++;
    if (bus_b.enable_out !== 12'h00D || bus_b.busy !== 1'b1)
      $display("FAIL limit_hold: got en=%h busy=%b, want 00D/1", bus_b.enable_out, bus_b.busy);
    else passed++;
  endtask

  task automatic test_drop_in_dwell();
    bus_a.req_enable = 12'h000;
    step();
    checks++;
    if (bus_a.enable_out !== 12'h000)
      $display("FAIL drop_all: got %h, want 000", bus_a.enable_out);
    else passed++;
    repeat (8) step();
    bus_a.req_enable = 12'h0F0;
    step();
    checks++;
    if (bus_a.enable_out !== 12'h010 || bus_a.busy !== 1'b1)
      $display("FAIL dwell_first_on: got en=%h busy=%b, want 010/1", bus_a.enable_out, bus_a.busy);
    else passed++;
    bus_a.req_enable = 12'h000;
    step();
    checks++;
    if (bus_a.enable_out !== 12'h000 || bus_a.busy !== 1'b0)
      $display("FAIL dwell_drop: got en=%h busy=%b, want 000/0", bus_a.enable_out, bus_a.busy);
    else passed++;
    bus_a.req_enable = 12'h001;
    for (int e = 3; e <= 6; e++) begin
      step();
      checks++;
      if (bus_a.enable_out !== ((e == 6) ? 12'h001 : 12'h000))
        $display("FAIL dwell_finish e=%0d: got %h, want %h", e, bus_a.enable_out,
                 ((e == 6) ? 12'h001 : 12'h000));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bus_a.req_enable = 12'h000;
    repeat (8) step();
    bus_a.req_enable = 12'hFFF;
    repeat (16) step();
    checks++;
    if (bus_a.enable_out !== 12'h00F)
      $display("FAIL mid_four_on: got %h, want 00F", bus_a.enable_out);
    else passed++;
    repeat (2) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.enable_out, bus_a.err_clear_out, bus_a.err_sticky, bus_a.busy, bus_a.at_limit} !== 38'd0)
      $display("FAIL mid_async_reset: got en=%h busy=%b lim=%b, want all 0",
               bus_a.enable_out, bus_a.busy, bus_a.at_limit);
    else passed++;
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (bus_a.enable_out !== ((e == 6) ? 12'h003 : 12'h001))
        $display("FAIL mid_restart e=%0d: got %h, want %h", e, bus_a.enable_out,
                 ((e == 6) ? 12'h003 : 12'h001));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_stagger();
    test_error();
    test_clear();
    test_limit();
    test_drop_in_dwell();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
